// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory responder.
// Holds the accmodule grant encodings, the master index mapping and the
// per-master transfer state enum used by resp_chan and mem_responder.
package mem_arb_pkg;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_M1   = 2'b01;
    localparam logic [1:0] ACC_M2   = 2'b10;
    localparam logic [1:0] ACC_M3   = 2'b11;

    localparam int M1          = 0;
    localparam int M2          = 1;
    localparam int M3          = 2;
    localparam int NUM_MASTERS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_SUSP   = 2'b10
    } chan_state_t;

    // Grant code that selects the master with the given index.
    function automatic logic [1:0] acc_code(input int idx);
        return 2'(idx + 1);
    endfunction

endpackage

// File: rtl/resp_chan.sv
// resp_chan: one master's transfer tracker.
// Keeps the remaining-beat count and IDLE/ACTIVE/SUSP state, and flags the
// final beat combinationally. The caller gates 'grant' with reset, so done
// is already low during a reset cycle.
module resp_chan
    import mem_arb_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grant,
    input  logic [LEN_W-1:0] len,
    output logic             done,
    output logic             pending
);

    chan_state_t      state;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] eff;
    logic             eff_is_one;

    // Effective beat count for this cycle: fresh length when idle, else the remainder.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        eff = rem;
        if (state == ST_IDLE) begin
            eff = (len == '0) ? LEN_W'(1) : len;
        end
        eff_is_one = (eff == LEN_W'(1));
        done       = grant && eff_is_one;
    end

    // Beat bookkeeping: consume a beat when granted, suspend an active transfer otherwise.
    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else if (grant) begin
            if (eff_is_one) begin
                state <= ST_IDLE;
                rem   <= '0;
            end else begin
                state <= ST_ACTIVE;
                rem   <= eff - LEN_W'(1);
            end
        end else if (state == ST_ACTIVE) begin
            state <= ST_SUSP;
        end
    end

    assign pending = (state != ST_IDLE);

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for a three-master arbiter.
// Decodes the current grant, tracks each master's transfer in a resp_chan
// instance and reports final beats. Optional statistics counters are built
// only when the macro MEM_RESPONDER_STATS_EN is defined; otherwise nb_beats
// and nb_resumes are tied to zero.
module mem_responder
    import mem_arb_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       accmodule,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [LEN_W-1:0] len_m2,
    input  logic [LEN_W-1:0] len_m3,
    output logic [2:0]       done,
    output logic             mem_en,
    output logic [2:0]       pending,
    output logic [CNT_W-1:0] nb_beats,
    output logic [CNT_W-1:0] nb_resumes
);

    logic [2:0] grant;

    // One-hot grant decode; nothing is granted while reset is asserted.
    always_comb begin
        grant = 3'b000;
        if (!reset) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                grant[m] = (accmodule == acc_code(m));
            end
        end
    end

    assign mem_en = |grant;

    resp_chan #(.LEN_W(LEN_W)) u_chan_m1 (
        .clk     (clk),
        .reset   (reset),
        .grant   (grant[M1]),
        .len     (len_m1),
        .done    (done[M1]),
        .pending (pending[M1])
    );

    resp_chan #(.LEN_W(LEN_W)) u_chan_m2 (
        .clk     (clk),
        .reset   (reset),
        .grant   (grant[M2]),
        .len     (len_m2),
        .done    (done[M2]),
        .pending (pending[M2])
    );

    resp_chan #(.LEN_W(LEN_W)) u_chan_m3 (
        .clk     (clk),
        .reset   (reset),
        .grant   (grant[M3]),
        .len     (len_m3),
        .done    (done[M3]),
        .pending (pending[M3])
    );

`ifdef MEM_RESPONDER_STATS_EN
    logic [2:0]       grant_q;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] resumes_q;
    logic             resume;

    // A pending transfer that was not granted last cycle is suspended, so
    // granting it now is a resume.
    assign resume = |(grant & pending & ~grant_q);

    // Saturating statistics counters plus last-cycle grant history.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= 3'b000;
            beats_q   <= '0;
            resumes_q <= '0;
        end else begin
            grant_q <= grant;
            if (mem_en && (beats_q != '1)) begin
                beats_q <= beats_q + 1'b1;
            end
            if (resume && (resumes_q != '1)) begin
                resumes_q <= resumes_q + 1'b1;
            end
        end
    end

    assign nb_beats   = beats_q;
    assign nb_resumes = resumes_q;
`else
    assign nb_beats   = '0;
    assign nb_resumes = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder.
// The stimulus process drives one cycle at a time, computes the expected
// outputs for that cycle from a transfer-level model and queues them; a
// monitor on the falling edge pops and compares against the DUT.
module tb_mem_responder;

    localparam int LEN_W   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    typedef struct {
        logic [2:0]       done;
        logic             mem_en;
        logic [2:0]       pending;
        logic [CNT_W-1:0] beats;
        logic [CNT_W-1:0] resumes;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       accmodule = 2'b00;
    logic [LEN_W-1:0] len_m1 = '0;
    logic [LEN_W-1:0] len_m2 = '0;
    logic [LEN_W-1:0] len_m3 = '0;
    logic [2:0]       done;
    logic             mem_en;
    logic [2:0]       pending;
    logic [CNT_W-1:0] nb_beats;
    logic [CNT_W-1:0] nb_resumes;

    int compared   = 0;
    int mismatched = 0;

    exp_t exp_q[$];

    // Reference model: a transfer is "in flight" with some beats left;
    // a resume is a grant to an in-flight transfer whose master did not
    // hold the grant in the previous cycle.
    bit in_flight[3];
    int beats_left[3];
    int last_master = -1;
    int beat_total  = 0;
    int resume_total = 0;
`ifdef MEM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    mem_responder #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .accmodule  (accmodule),
        .len_m1     (len_m1),
        .len_m2     (len_m2),
        .len_m3     (len_m3),
        .done       (done),
        .mem_en     (mem_en),
        .pending    (pending),
        .nb_beats   (nb_beats),
        .nb_resumes (nb_resumes)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("done",       32'(done),       32'(e.done));
            check("mem_en",     32'(mem_en),     32'(e.mem_en));
            check("pending",    32'(pending),    32'(e.pending));
            check("nb_beats",   32'(nb_beats),   32'(e.beats));
            check("nb_resumes", 32'(nb_resumes), 32'(e.resumes));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic drive_cycle(input bit rst, input logic [1:0] acc,
                               input logic [LEN_W-1:0] l1, input logic [LEN_W-1:0] l2,
                               input logic [LEN_W-1:0] l3);
        exp_t e;
        int   m;
        int   n;
        int   lens[3];
        @(posedge clk);
        #1;
        reset     = rst;
        accmodule = acc;
        len_m1    = l1;
        len_m2    = l2;
        len_m3    = l3;
        lens[0] = int'(l1);
        lens[1] = int'(l2);
        lens[2] = int'(l3);

        e.done    = 3'b000;
        e.mem_en  = 1'b0;
        e.pending = {in_flight[2], in_flight[1], in_flight[0]};
        e.beats   = STATS ? CNT_W'(beat_total) : '0;
        e.resumes = STATS ? CNT_W'(resume_total) : '0;

        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                in_flight[i]  = 1'b0;
                beats_left[i] = 0;
            end
            last_master  = -1;
            beat_total   = 0;
            resume_total = 0;
        end else begin
            m = int'(acc) - 1;
            if (m >= 0) begin
                e.mem_en = 1'b1;
                n = in_flight[m] ? beats_left[m] : ((lens[m] == 0) ? 1 : lens[m]);
                if (n == 1) e.done[m] = 1'b1;
                if (in_flight[m] && last_master != m && resume_total < CNT_MAX) resume_total++;
                if (beat_total < CNT_MAX) beat_total++;
                beats_left[m] = n - 1;
                in_flight[m]  = (n > 1);
            end
            last_master = m;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 2'b00, '0, '0, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // Reset cycle with a live grant: nothing may be served.
        drive_cycle(1'b1, 2'b01, 4'd3, 4'd0, 4'd0);

        // Three-beat transfer for M1.
        repeat (3) drive_cycle(1'b0, 2'b01, 4'd3, 4'd0, 4'd0);
        idle_cycle();

        // Zero length is one beat.
        drive_cycle(1'b0, 2'b10, 4'd0, 4'd0, 4'd0);
        idle_cycle();

        // M3 suspended by a one-beat M1 transfer, then resumed.
        drive_cycle(1'b0, 2'b11, 4'd0, 4'd0, 4'd4);
        drive_cycle(1'b0, 2'b01, 4'd1, 4'd0, 4'd9);
        repeat (3) drive_cycle(1'b0, 2'b11, 4'd0, 4'd0, 4'd9);

        // Reset mid-transfer discards it; the next grant reloads len.
        repeat (2) drive_cycle(1'b0, 2'b10, 4'd0, 4'd5, 4'd0);
        drive_cycle(1'b1, 2'b10, 4'd0, 4'd5, 4'd0);
        drive_cycle(1'b0, 2'b10, 4'd0, 4'd1, 4'd0);

        // Gaps of no grant suspend and later resume.
        drive_cycle(1'b0, 2'b01, 4'd2, 4'd0, 4'd0);
        drive_cycle(1'b0, 2'b00, 4'd7, 4'd0, 4'd0);
        drive_cycle(1'b0, 2'b00, 4'd7, 4'd0, 4'd0);
        drive_cycle(1'b0, 2'b01, 4'd7, 4'd0, 4'd0);

        // Back-to-back switch after a done: no bubble.
        drive_cycle(1'b0, 2'b10, 4'd0, 4'd1, 4'd2);
        drive_cycle(1'b0, 2'b11, 4'd0, 4'd1, 4'd2);
        drive_cycle(1'b0, 2'b11, 4'd0, 4'd1, 4'd2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive_cycle($urandom_range(0, 39) == 0,
                        2'($urandom_range(0, 3)),
                        LEN_W'($urandom_range(0, 15)),
                        LEN_W'($urandom_range(0, 15)),
                        LEN_W'($urandom_range(0, 15)));
        end

`ifdef MEM_RESPONDER_STATS_EN
        // Drive the beat counter to its ceiling and past it.
        drive_cycle(1'b1, 2'b00, '0, '0, '0);
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive_cycle(1'b0, 2'b01, 4'd1, 4'd0, 4'd0);
        end
`endif
        idle_cycle();

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of per-master transfer-length fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 accmodule  input  2  current grant: 00 none, 01 M1, 10 M2, 11 M3.
REQ-006 len_m1, len_m2, len_m3  input  LEN_W each  beat count of a new transfer for that master; sampled on its first granted beat.
REQ-007 done  output  3  done[0]=M1, done[1]=M2, done[2]=M3; final-beat indication to the arbiter.
REQ-008 mem_en  output  1  memory access performed this cycle (accmodule != 00).
REQ-009 pending  output  3  per-master flag: transfer started and not finished (includes suspended).
REQ-010 nb_beats  output  CNT_W  total granted beats served.
REQ-011 nb_resumes  output  CNT_W  count of transfers resumed after suspension.

Function
REQ-012 Per master m SHALL keep a remaining-beat register rem[m] and state IDLE / ACTIVE / SUSP.
REQ-013 Granted beat for m: accmodule selects m; mem_en SHALL be 1 in that same cycle, 0 otherwise.
REQ-014 Effective count eff = len_m (0 treated as 1) if m is IDLE, else rem[m].
REQ-015 done[m] SHALL be combinational: 1 iff granted beat for m and eff == 1; at most one done bit high.
REQ-016 On a granted beat with eff > 1: rem[m] <= eff-1, state <= ACTIVE.
REQ-017 On a granted beat with eff == 1: rem[m] <= 0, state <= IDLE.
REQ-018 ACTIVE master not granted in a cycle SHALL move to SUSP, rem[m] held.
REQ-019 SUSP master granted again SHALL resume from rem[m] without reloading len; nb_resumes increments that cycle.
REQ-020 len_m SHALL be ignored while m is ACTIVE or SUSP.
REQ-021 pending[m] = (state != IDLE), registered.
REQ-022 Grant switching to another master in the cycle after a done SHALL start that master with no bubble.
REQ-023 accmodule = 00 SHALL leave all rem[] unchanged; ACTIVE masters go to SUSP.
REQ-024 nb_beats increments by 1 per granted beat; both counters saturate at all-ones, no wrap.

Reset
REQ-025 On reset: all states IDLE, rem[]=0, pending=000, nb_beats=0, nb_resumes=0.
REQ-026 done and mem_en SHALL be 0 during a reset cycle regardless of accmodule.
REQ-027 Reset mid-transfer SHALL discard the transfer; next grant reloads len.

Configuration
REQ-028 Macro MEM_RESPONDER_STATS_EN defined: nb_beats and nb_resumes implemented per REQ-019/REQ-024.
REQ-029 Macro undefined: no counter flops; nb_beats and nb_resumes SHALL be constant 0; all other behaviour identical.

Structure
REQ-030 Package mem_arb_pkg SHALL hold accmodule encodings (ACC_NONE, ACC_M1, ACC_M2, ACC_M3), master indices M1=0, M2=1, M3=2, and the per-master state enum.
REQ-031 Sub-module resp_chan SHALL implement one master's state/rem/done logic; mem_responder instantiates it three times plus the counters.

Verification
REQ-032 len_m1=3, accmodule=01 for 3 cycles -> done=000,000,001; pending[0] 0,1,1 then 0; nb_beats=3.
REQ-033 len_m2=0, accmodule=10 one cycle -> done[1]=1 same cycle; pending[1] stays 0.
REQ-034 len_m3=4, grant 11 x1, 01 x1 (len_m1=1), 11 x3 -> done[0] in cycle 2, done[2] in cycle 5; nb_resumes=1.
REQ-035 len_m2=5, grant 10 x2, then reset, then 10 x1 with len_m2=1 -> done[1]=1 on that beat; rem reloaded.
REQ-036 len_m1=2, accmodule 01,00,00,01 -> done[0] only in cycle 4; mem_en 1,0,0,1.
REQ-037 With STATS_EN: force nb_beats near 0xFFFF, 3 more beats -> holds 0xFFFF; without macro: counters read 0 throughout.
